// File: rtl/dmem_responder.sv
// dmem_responder: single-port word-addressed data memory behind a
// valid/ready request channel and a valid/ready response channel.
// One transaction at a time: IDLE -> (WAIT x WAIT_CYCLES) -> RESP -> IDLE.
// The memory is read/written on the edge that enters RESP; the response
// data and error flag are registered at that edge and held until consumed.
// Optional feature macro: DMEM_RSP_MISALIGN_CHK_EN -- when defined, any
// access with addr[1:0] != 0 faults (rsp_err=1, rdata=0, no write).
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_acc_we;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [3:0]  w_acc_wstrb;
  logic [29:0] w_word;
  logic [AW-1:0] w_idx;
  logic        w_oob;
  logic        w_misalign;
  logic        w_fault;
  logic        w_mem_we;
  logic [31:0] w_mem_rd;

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  assign w_accept     = req_valid && (r_state == IDLE);
  assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);

  // Select access operands: live inputs when going straight from IDLE to RESP, captured copy otherwise.
  always_comb begin
    w_acc_we    = r_we;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    w_acc_wstrb = r_wstrb;
    if (r_state == IDLE) begin
      w_acc_we    = req_we;
      w_acc_addr  = req_addr;
      w_acc_wdata = req_wdata;
      w_acc_wstrb = req_wstrb;
    end else begin
      w_acc_we    = r_we;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      w_acc_wstrb = r_wstrb;
    end
  end

  assign w_word = w_acc_addr[31:2];
  assign w_idx  = w_word[AW-1:0];
  assign w_oob  = ({2'b00, w_word} >= 32'(DEPTH_WORDS));

`ifdef DMEM_RSP_MISALIGN_CHK_EN
  assign w_misalign = (w_acc_addr[1:0] != 2'b00);
`else
  // Byte offset is deliberately ignored in this build.
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^w_acc_addr[1:0];
  assign w_misalign        = 1'b0;
`endif

  assign w_fault  = w_oob || w_misalign;
  // rst_n gating keeps a store from landing while reset is held.
  assign w_mem_we = w_enter_resp && w_acc_we && !w_fault && rst_n;
  assign w_mem_rd = r_mem[w_idx];

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = RESP;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request fields on the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

  // Register the response on RESP entry; held stable until the next access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= (!w_fault && !w_acc_we) ? w_mem_rd : 32'd0;
      r_err   <= w_fault;
    end
  end

  // Byte-lane store into the backing array (contents are never reset).
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=1).
// Stimulus pushes the expected response; a monitor pops and compares on
// every response handshake and also checks the response latency.
module tb_dmem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int WAIT_CYCLES = 1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int stim_checks = 0;
  int stim_errors = 0;
  int mon_checks  = 0;
  int mon_errors  = 0;

  logic lat_armed = 1'b0;
  int   lat_cnt   = 0;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency counter: the acceptance edge counts as 1, each later edge adds 1,
  // so the edge that raises rsp_valid must be number WAIT_CYCLES+1.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        lat_armed = 1'b0;
      end else if (req_valid && req_ready) begin
        lat_armed = 1'b1;
        lat_cnt   = 1;
      end else if (lat_armed && rsp_valid) begin
        lat_armed = 1'b0;
      end else if (lat_armed) begin
        lat_cnt = lat_cnt + 1;
      end
    end
  end

  // Response monitor: latency check plus scoreboard compare on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (lat_armed && rsp_valid) begin
          mon_checks++;
          if (lat_cnt != WAIT_CYCLES + 1) begin
            mon_errors++;
            $display("FAIL latency: got %0d edges, required %0d", lat_cnt, WAIT_CYCLES + 1);
          end
        end
        if (rsp_valid && rsp_ready) begin
          mon_checks++;
          if (exp_q.size() == 0) begin
            mon_errors++;
            $display("FAIL unexpected_rsp: got rdata=%08h err=%0b, required no response", rsp_rdata, rsp_err);
          end else begin
            mon_e = exp_q.pop_front();
            if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err) begin
              mon_errors++;
              $display("FAIL rsp_data: got rdata=%08h err=%0b, required rdata=%08h err=%0b",
                       rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    stim_checks++;
    if (got !== req) begin
      stim_errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic push,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      stim_checks++;
      stim_errors++;
      $display("FAIL req_accept: got req_ready=%0b, required 1 within 100 cycles", req_ready);
    end else begin
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      if (push) begin
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && req_ready) && n < 100);
    stim_checks++;
    if (!(exp_q.size() == 0 && req_ready)) begin
      stim_errors++;
      $display("FAIL %s_timeout: got %0d responses outstanding, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_wstrb = 4'd0;
    rsp_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    rst_n = 1'b1;

    // Full store then load.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0,        4'b0000, 1'b1, 32'hDEADBEEF, 1'b0);
    // Single-lane store merges into the word.
    do_req(1'b1, 32'h10, 32'h00000055, 4'b0001, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0,        4'b0000, 1'b1, 32'hDEADBE55, 1'b0);
    // Empty strobe is a no-op.
    do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0,        4'b0000, 1'b1, 32'hDEADBE55, 1'b0);
    // Alternate lanes: 11223344 with AABBCCDD on lanes 3 and 1 -> AA22CC44.
    do_req(1'b1, 32'h14, 32'h11223344, 4'b1111, 1'b1, 32'h0, 1'b0);
    do_req(1'b1, 32'h14, 32'hAABBCCDD, 4'b1010, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 32'h14, 32'h0,        4'b0000, 1'b1, 32'hAA22CC44, 1'b0);
    // Out of range: 0x1000 is word 1024, which would alias word 0 if unchecked.
    do_req(1'b1, 32'h0,    32'h0BADF00D, 4'b1111, 1'b1, 32'h0, 1'b0);
    do_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 32'h1000, 32'h0,        4'b0000, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 32'h0,    32'h0,        4'b0000, 1'b1, 32'h0BADF00D, 1'b0);
    wait_done("basic");

    // Backpressure: hold rsp_ready low for 5 RESP cycles; a request offered meanwhile is ignored.
    rsp_ready = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 4'b0000, 1'b1, 32'hDEADBE55, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rdata",     64'(rsp_rdata), 64'hDEADBE55);
      check("hold_err",       64'(rsp_err),   64'd0);
      check("hold_req_ready", 64'(req_ready), 64'd0);
      if (i == 1) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        req_wstrb = 4'b1111;
      end else if (i == 4) begin
        req_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_req_ready", 64'(req_ready), 64'd1);
    check("release_rsp_valid", 64'(rsp_valid), 64'd0);

    // Byte offset: ignored by default, faults with the misalignment check built in.
`ifdef DMEM_RSP_MISALIGN_CHK_EN
    do_req(1'b0, 32'h13, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1);
`else
    do_req(1'b0, 32'h13, 32'h0, 4'b0000, 1'b1, 32'hDEADBE55, 1'b0);
`endif
    wait_done("misalign");

    // Reset during WAIT of a store drops it.
    do_req(1'b1, 32'h20, 32'h00000000, 4'b1111, 1'b1, 32'h0, 1'b0);
    wait_done("preclear");
    do_req(1'b1, 32'h20, 32'h12345678, 4'b1111, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    do_req(1'b0, 32'h20, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b0);
    wait_done("postrst");

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             stim_checks + mon_checks, stim_errors + mon_errors);
    $finish;
  end

endmodule
